// File: rtl/ether_rx_ctrl.sv
// RMII receive controller: packs dibits into bytes, filters by destination
// address and length, and writes accepted frames into a single-frame buffer.
module ether_rx_ctrl #(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter int          MIN_BYTES = 64,
    parameter int          MAX_BYTES = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic [10:0] frame_len,
    input  logic        frame_ack,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, DST, DATA, DROP, HOLD} state_t;

    state_t      state, state_nxt;
    logic        axiiv_d;
    logic [1:0]  phase, phase_nxt;
    logic [5:0]  sh, sh_nxt;
    logic [10:0] count, count_nxt;
    logic        uc, uc_nxt, bc, bc_nxt;
    logic        pend, pend_nxt;
    logic        wr_en_nxt;
    logic [10:0] wr_addr_nxt;
    logic [7:0]  wr_data_nxt;
    logic        done_nxt;
    logic [10:0] len_nxt;
    logic [15:0] drop_nxt;
    logic        drop_inc;
    logic        rise;
    logic        byte_done;
    logic [7:0]  new_byte;

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rise      = axiiv & ~axiiv_d;
    assign byte_done = axiiv && (phase == 2'd3);
    // Earlier dibits sit in sh with dibit 0 at the bottom; the live dibit completes the byte.
    assign new_byte  = {axiid, sh};

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        sh_nxt      = sh;
        count_nxt   = count;
        uc_nxt      = uc;
        bc_nxt      = bc;
        pend_nxt    = pend;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = 1'b0;
        len_nxt     = frame_len;
        drop_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = DST;
                    phase_nxt = 2'd1;
                    sh_nxt    = {axiid, sh[5:2]};
                    count_nxt = 11'd0;
                    uc_nxt    = 1'b1;
                    bc_nxt    = 1'b1;
                end
            end
            HOLD: begin
                // An ack coincident with a new frame frees the buffer for that frame.
                if (rise && frame_ack) begin
                    pend_nxt  = 1'b0;
                    state_nxt = DST;
                    phase_nxt = 2'd1;
                    sh_nxt    = {axiid, sh[5:2]};
                    count_nxt = 11'd0;
                    uc_nxt    = 1'b1;
                    bc_nxt    = 1'b1;
                end else if (rise) begin
                    state_nxt = DROP;
                end else if (frame_ack) begin
                    pend_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            DST, DATA: begin
                if (!axiiv) begin
                    if (phase != 2'd0 || count < 11'(MIN_BYTES)) begin
                        drop_inc  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        len_nxt   = count;
                        done_nxt  = 1'b1;
                        pend_nxt  = 1'b1;
                        state_nxt = HOLD;
                    end
                end else begin
                    phase_nxt = phase + 2'd1;
                    sh_nxt    = {axiid, sh[5:2]};
                    if (byte_done) begin
                        if (state == DST) begin
                            uc_nxt      = uc && (new_byte == mac_byte(count[2:0]));
                            bc_nxt      = bc && (new_byte == 8'hFF);
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = count;
                            wr_data_nxt = new_byte;
                            count_nxt   = count + 11'd1;
                            if (!uc_nxt && !bc_nxt)
                                state_nxt = DROP;
                            else if (count == 11'd5)
                                state_nxt = DATA;
                        end else if (count >= 11'(MAX_BYTES)) begin
                            state_nxt = DROP;
                        end else begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = count;
                            wr_data_nxt = new_byte;
                            count_nxt   = count + 11'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (!axiiv) begin
                    drop_inc  = 1'b1;
                    state_nxt = pend ? HOLD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        drop_nxt = drop_inc ? sat_inc(drop_cnt) : drop_cnt;
    end

    // axiiv_d resets high so a frame already in progress at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            axiiv_d    <= 1'b1;
            phase      <= 2'd0;
            count      <= 11'd0;
            uc         <= 1'b0;
            bc         <= 1'b0;
            pend       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 11'd0;
            wr_data    <= 8'd0;
            frame_done <= 1'b0;
            frame_len  <= 11'd0;
            drop_cnt   <= 16'd0;
        end else begin
            state      <= state_nxt;
            axiiv_d    <= axiiv;
            phase      <= phase_nxt;
            count      <= count_nxt;
            uc         <= uc_nxt;
            bc         <= bc_nxt;
            pend       <= pend_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            frame_done <= done_nxt;
            frame_len  <= len_nxt;
            drop_cnt   <= drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        sh <= sh_nxt;
    end

endmodule

// File: doc/ether_rx_ctrl.md
ETHER_RX_CTRL -- requirements
Module: ether_rx_ctrl

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h02_00_00_00_00_01, station address accepted as destination.
REQ-002 SHALL have parameter MIN_BYTES, default 64, minimum legal frame length in bytes, FCS included.
REQ-003 SHALL have parameter MAX_BYTES, default 1518, maximum legal frame length in bytes, FCS included.
REQ-004 SHALL have port clk  input  1  single 50 MHz clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port axiiv  input  1  dibit valid from the RMII receiver, high from first post-SFD dibit to end of carrier.
REQ-007 SHALL have port axiid  input  2  received dibit; the first dibit of each byte is bits [1:0].
REQ-008 SHALL have port wr_en  output  1  buffer write strobe, one cycle per byte.
REQ-009 SHALL have port wr_addr  output  11  buffer byte address, 0 = first destination byte.
REQ-010 SHALL have port wr_data  output  8  byte written.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse, accepted frame ready in buffer.
REQ-012 SHALL have port frame_len  output  11  byte count of the accepted frame, held until frame_ack.
REQ-013 SHALL have port frame_ack  input  1  consumer has read the buffer; frees it.
REQ-014 SHALL have port drop_cnt  output  16  saturating count of dropped frames.

Function
REQ-015 SHALL pack four consecutive valid dibits into one byte, dibit n into bits [2n+1:2n], byte complete on the 4th dibit.
REQ-016 SHALL run states IDLE, DST, DATA, DROP, HOLD.
REQ-017 IDLE: on rising axiiv, if buffer free go DST, byte count 0; if buffer held (HOLD pending) go DROP.
REQ-018 DST: write bytes 0-5; compare each to MAC_ADDR (byte 0 = MAC_ADDR[47:40]) or 8'hFF; any byte matching neither -> DROP after that byte; all six match one of {MAC_ADDR, all-FF} consistently -> DATA.
REQ-019 DATA: write each completed byte at wr_addr = byte count, then increment count.
REQ-020 wr_en SHALL assert in the cycle after the 4th dibit of a byte is sampled, with wr_addr and wr_data valid in that cycle (latency 1 cycle).
REQ-021 When count would exceed MAX_BYTES, no write for that byte; go DROP.
REQ-022 On axiiv falling in DST or DATA: if dibit phase not 0 (partial byte), or count < MIN_BYTES -> drop; otherwise frame_len <= count, pulse frame_done the next cycle, go HOLD.
REQ-023 DROP: suppress wr_en; on axiiv low increment drop_cnt once, go IDLE (or HOLD if a frame is still pending).
REQ-024 drop_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-025 HOLD: buffer owned by consumer, frame_len stable; frame_ack returns to IDLE; frames arriving meanwhile are dropped and counted, without disturbing HOLD.
REQ-026 frame_ack outside HOLD SHALL be ignored.
REQ-027 frame_ack in the same cycle as a new frame's first dibit SHALL free the buffer first; that frame is received normally.
REQ-028 Byte count SHALL be 11 bits; MAX_BYTES < 2048 guarantees no wrap.
REQ-029 Every dropped frame (address, short, long, partial, busy) SHALL increment drop_cnt by exactly 1.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_len=0, drop_cnt=0, dibit phase 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame without a count; after release, reception resumes only at the next rising axiiv.

Verification
REQ-032 64-byte frame to MAC_ADDR -> 64 wr_en pulses, addr 0..63, bytes match, one frame_done, frame_len=64, drop_cnt=0.
REQ-033 Frame to FF:FF:FF:FF:FF:FF, 100 bytes -> accepted, frame_len=100; frame to 02:00:00:00:00:02 -> 6 writes max, no frame_done, drop_cnt=1.
REQ-034 60-byte frame -> drop_cnt +1; 1519-byte frame -> exactly 1518 writes, no frame_done, drop_cnt +1; 257-dibit frame -> drop.
REQ-035 Second valid frame before frame_ack -> no writes, drop_cnt +1, frame_len of first unchanged; ack coincident with next frame start -> next frame accepted.
REQ-036 rst_n low at byte 30 of a valid frame -> outputs zero at once, no frame_done, drop_cnt=0; next frame received normally.
REQ-037 Force 65536 drops -> drop_cnt holds 16'hFFFF.
